// File: rtl/adc_frame_sequencer.sv
// Sample-clock-domain frame sequencer: on each frame tick it converts every enabled ADC
// channel in ascending order and writes the results into the FIFO write port.
module adc_frame_sequencer #(
    parameter int          NUM_CH   = 8,
    parameter int          TIMEOUT  = 255,
    parameter logic [15:0] ERR_WORD = 16'h8000
) (
    input  logic                      sample_clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         chan_mask,
    input  logic [15:0]               frame_period,
    input  logic                      fifo_full,
    input  logic                      adc_eoc,
    input  logic [15:0]               adc_data,
    output logic                      adc_start,
    output logic [$clog2(NUM_CH)-1:0] adc_chan,
    output logic                      done,
    output logic [$clog2(NUM_CH)-1:0] atmchsel,
    output logic [15:0]               data_in,
    output logic                      last_word,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [7:0]                overrun_cnt,
    output logic [7:0]                drop_cnt
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_START,
        S_CONVERT,
        S_WRITE
    } state_t;

    typedef struct packed {
        logic            found;
        logic [CH_W-1:0] idx;
    } pick_t;

    // Lowest set bit of mask at or above position 'from'.
    function automatic pick_t pick_from(input logic [NUM_CH-1:0] mask, input int from);
        pick_t p;
        p = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                p.found = 1'b1;
                p.idx   = CH_W'(i);
            end
        end
        return p;
    endfunction

    state_t           state_q;
    logic [NUM_CH-1:0] mask_q;
    logic [CH_W-1:0]  ch_q;
    logic [TMO_W-1:0] tmo_q;
    logic [15:0]      timer_q, timer_d;
    logic             en_q, first_q;
    logic             tick, period_hit;
    logic             adc_start_q, done_q, last_word_q, busy_q, timeout_err_q;
    logic [CH_W-1:0]  adc_chan_q, atmchsel_q;
    logic [15:0]      data_in_q;
    logic [7:0]       overrun_q, drop_q;
    pick_t            first_pick, next_pick;

    assign first_pick = pick_from(chan_mask, 0);
    assign next_pick  = pick_from(mask_q, int'(ch_q) + 1);

    // The tick comes one cycle after the enable rise so it lands in WAIT_TICK, not IDLE.
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        tick    = 1'b0;
        timer_d = timer_q;
        if (frame_period == 16'd0) begin
            period_hit = (state_q == S_WAIT_TICK);
        end else begin
            period_hit = (timer_q >= frame_period - 16'd1);
        end
        if (!enable) begin
            timer_d = 16'd0;
        end else begin
            tick = en_q && (first_q || period_hit);
            if (first_q || tick || (frame_period == 16'd0)) begin
                timer_d = 16'd0;
            end else begin
                timer_d = timer_q + 16'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q    <= 1'b0;
            first_q <= 1'b0;
            timer_q <= 16'd0;
        end else begin
            en_q    <= enable;
            first_q <= enable && !en_q;
            timer_q <= timer_d;
        end
    end

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            ch_q          <= '0;
            tmo_q         <= '0;
            adc_start_q   <= 1'b0;
            adc_chan_q    <= '0;
            done_q        <= 1'b0;
            atmchsel_q    <= '0;
            data_in_q     <= 16'd0;
            last_word_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 8'd0;
            drop_q        <= 8'd0;
        end else begin
            adc_start_q <= 1'b0;
            done_q      <= 1'b0;
            last_word_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (enable) state_q <= S_WAIT_TICK;
                end
                S_WAIT_TICK: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                    end else if (tick) begin
                        if (fifo_full) begin
                            if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
                        end else begin
                            mask_q <= chan_mask;
                            if (first_pick.found) begin
                                ch_q        <= first_pick.idx;
                                adc_chan_q  <= first_pick.idx;
                                adc_start_q <= 1'b1;
                                busy_q      <= 1'b1;
                                state_q     <= S_START;
                            end
                        end
                    end
                end
                S_START: begin
                    tmo_q   <= '0;
                    state_q <= S_CONVERT;
                end
                S_CONVERT: begin
                    if (adc_eoc || (tmo_q == TMO_W'(TIMEOUT))) begin
                        done_q      <= 1'b1;
                        atmchsel_q  <= ch_q;
                        data_in_q   <= adc_eoc ? adc_data : ERR_WORD;
                        last_word_q <= !next_pick.found;
                        if (!adc_eoc) timeout_err_q <= 1'b1;
                        state_q     <= S_WRITE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_WRITE: begin
                    if (next_pick.found) begin
                        ch_q        <= next_pick.idx;
                        adc_chan_q  <= next_pick.idx;
                        adc_start_q <= 1'b1;
                        state_q     <= S_START;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= enable ? S_WAIT_TICK : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (tick && (state_q inside {S_START, S_CONVERT, S_WRITE}) && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end
        end
    end

    assign adc_start   = adc_start_q;
    assign adc_chan    = adc_chan_q;
    assign done        = done_q;
    assign atmchsel    = atmchsel_q;
    assign data_in     = data_in_q;
    assign last_word   = last_word_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign overrun_cnt = overrun_q;
    assign drop_cnt    = drop_q;

endmodule
